crtc_row_dma: RTL and testbench

Parametrised successor of the CRTC text-row DMA path. It fetches one display row of VRAM bytes per request over a Z80 busreq/busack handshake into a double-banked row buffer, which the display side reads from the opposite bank. Programmable start address and terminal count are double-buffered until frame start, and the source address wraps at terminal count. The block sits between the CPU I/O decode (port 60h writes), the Z80 bus arbiter, and the character/attribute pipeline.

---
 rtl/crtc_row_dma.sv | 217 +++++++++++++++++++++
 tb/tb_crtc_row_dma.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_row_dma.sv
// CRTC text-row DMA: fetches one display row of VRAM bytes per request into a
// double-banked row buffer. Define CRTC_DMA_BURST_EN to split each row into bursts.
module crtc_row_dma #(
  parameter int          ADR_W     = 16,
  parameter int          SIZE_W    = 15,
  parameter int          ROW_BYTES = 120,
  parameter int          BUF_DEPTH = 128,
  parameter int unsigned DEF_START = 'hF300,
  parameter int          DEF_SIZE  = 2999,
  parameter int          BURST_LEN = 8,
  parameter int          GAP_CYC   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         row_req,
  input  logic                         dma_en,
  input  logic                         reg_we,
  input  logic                         reg_sel,
  input  logic [7:0]                   reg_wdata,
  input  logic                         ff_clr,
  input  logic                         busack,
  input  logic [7:0]                   ram_data,
  output logic                         busreq,
  output logic [ADR_W-1:0]             ram_adr,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_adr,
  output logic [7:0]                   rd_data,
  output logic                         busy,
  output logic                         row_done,
  output logic                         overrun
);
  localparam int DST_W = $clog2(BUF_DEPTH);
  localparam logic [ADR_W-1:0]  DEF_ST = ADR_W'(DEF_START);
  localparam logic [SIZE_W-1:0] DEF_SZ = SIZE_W'(DEF_SIZE);

  if (ROW_BYTES < 1 || ROW_BYTES > BUF_DEPTH || BURST_LEN < 1 || GAP_CYC < 1 ||
      ADR_W < 9 || ADR_W > 16 || SIZE_W < 9 || SIZE_W > 16) begin : g_bad_cfg
    $error("crtc_row_dma: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [ADR_W-1:0]  start_sh_q, start_sh_d, start_q, start_d, src_q, src_d;
  logic [SIZE_W-1:0] size_sh_q, size_sh_d, size_q, size_d, cnt_q, cnt_d;
  logic              ff_start_q, ff_start_d, ff_size_q, ff_size_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic              wr_bank_q, wr_bank_d, overrun_q, overrun_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        buf_mem [2*BUF_DEPTH];
  logic              buf_we, row_go;

`ifdef CRTC_DMA_BURST_EN
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int GCNT_W = $clog2(GAP_CYC + 1);
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
`endif

  assign row_go = row_req && dma_en;

  // CPU-side byte writes land in the shadow copies only; frame_start publishes them.
  always_comb begin
    start_sh_d = start_sh_q;
    size_sh_d  = size_sh_q;
    ff_start_d = ff_start_q;
    ff_size_d  = ff_size_q;
    if (reg_we && !reg_sel) begin
      if (ff_start_q) start_sh_d[ADR_W-1:8] = reg_wdata[ADR_W-9:0];
      else            start_sh_d[7:0]       = reg_wdata;
      ff_start_d = ~ff_start_q;
    end
    if (reg_we && reg_sel) begin
      if (ff_size_q) size_sh_d[SIZE_W-1:8] = reg_wdata[SIZE_W-9:0];
      else           size_sh_d[7:0]        = reg_wdata;
      ff_size_d = ~ff_size_q;
    end
    if (ff_clr) begin
      ff_start_d = 1'b0;
      ff_size_d  = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    size_d    = size_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    wr_bank_d = wr_bank_q;
    overrun_d = overrun_q;
    buf_we    = 1'b0;
`ifdef CRTC_DMA_BURST_EN
    bcnt_d    = bcnt_q;
    gcnt_d    = gcnt_q;
`endif
    if (frame_start) begin
      // Reload wins over everything; a row in flight is dropped without swapping banks.
      start_d   = start_sh_q;
      size_d    = size_sh_q;
      src_d     = start_sh_q;
      cnt_d     = '0;
      dst_d     = '0;
      overrun_d = 1'b0;
      state_d   = row_go ? S_REQ : S_IDLE;
`ifdef CRTC_DMA_BURST_EN
      bcnt_d    = '0;
`endif
    end else begin
      if (row_req && busy) overrun_d = 1'b1;
      case (state_q)
        S_IDLE: if (row_go) begin
          state_d = S_REQ;
          dst_d   = '0;
`ifdef CRTC_DMA_BURST_EN
          bcnt_d  = '0;
`endif
        end
        S_REQ:  if (busack) state_d = S_ADDR;
        S_ADDR: if (busack) state_d = S_DATA;
        S_DATA: begin
          buf_we = 1'b1;
          if (cnt_q == size_q) begin
            src_d = start_q;
            cnt_d = '0;
          end else begin
            src_d = src_q + ADR_W'(1);
            cnt_d = cnt_q + SIZE_W'(1);
          end
          dst_d = dst_q + DST_W'(1);
          if (dst_q == DST_W'(ROW_BYTES - 1)) state_d = S_DONE;
`ifdef CRTC_DMA_BURST_EN
          else if (bcnt_q == BCNT_W'(BURST_LEN - 1)) begin
            state_d = S_GAP;
            bcnt_d  = '0;
            gcnt_d  = '0;
          end else begin
            state_d = S_ADDR;
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
`else
          else state_d = S_ADDR;
`endif
        end
        S_DONE: begin
          wr_bank_d = ~wr_bank_q;
          state_d   = S_IDLE;
        end
`ifdef CRTC_DMA_BURST_EN
        S_GAP: begin
          if (gcnt_q == GCNT_W'(GAP_CYC - 1)) state_d = S_REQ;
          else gcnt_d = gcnt_q + GCNT_W'(1);
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_sh_q <= DEF_ST;
      size_sh_q  <= DEF_SZ;
      start_q    <= DEF_ST;
      size_q     <= DEF_SZ;
      src_q      <= DEF_ST;
      cnt_q      <= '0;
      ff_start_q <= 1'b0;
      ff_size_q  <= 1'b0;
      dst_q      <= '0;
      wr_bank_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef CRTC_DMA_BURST_EN
      bcnt_q     <= '0;
      gcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_sh_q <= start_sh_d;
      size_sh_q  <= size_sh_d;
      start_q    <= start_d;
      size_q     <= size_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      ff_start_q <= ff_start_d;
      ff_size_q  <= ff_size_d;
      dst_q      <= dst_d;
      wr_bank_q  <= wr_bank_d;
      overrun_q  <= overrun_d;
`ifdef CRTC_DMA_BURST_EN
      bcnt_q     <= bcnt_d;
      gcnt_q     <= gcnt_d;
`endif
    end
  end

  // Display side always reads the bank the engine is not filling.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[{wr_bank_q, dst_q}] <= ram_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= buf_mem[{~wr_bank_q, rd_adr}];
  end

  // src stays put through ADDR and DATA, so the one-cycle VRAM latency lines up.
  assign ram_adr  = src_q;
  assign busreq   = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign busy     = busreq || (state_q == S_GAP);
  assign row_done = (state_q == S_DONE);
  assign overrun  = overrun_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_crtc_row_dma.sv
// Scoreboard bench for crtc_row_dma: expected row bytes are queued when a row is
// requested and popped while reading the display bank back after row_done.
module tb_crtc_row_dma;
  localparam int ROW_BYTES = 120;
`ifdef CRTC_DMA_BURST_EN
  localparam int EXP_BUSREQ = 255;
  localparam int EXP_GAPCYC = 56;
  localparam int EXP_FALLS  = 14;
`else
  localparam int EXP_BUSREQ = 241;
  localparam int EXP_GAPCYC = 0;
  localparam int EXP_FALLS  = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, frame_start, row_req, dma_en, reg_we, reg_sel, ff_clr, busack;
  logic [7:0]  reg_wdata, ram_data, rd_data;
  logic        busreq, busy, row_done, overrun;
  logic [15:0] ram_adr;
  logic [6:0]  rd_adr;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  logic [15:0] m_start_sh, m_start, m_src;
  logic [14:0] m_size_sh, m_size, m_cnt;
  bit          m_ff0, m_ff1;

  int   busreq_cyc = 0, done_cnt = 0, falls = 0, gap_cyc = 0;
  logic busreq_prev = 1'b0;

  crtc_row_dma dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .row_req(row_req),
    .dma_en(dma_en), .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .ff_clr(ff_clr), .busack(busack), .ram_data(ram_data), .busreq(busreq),
    .ram_adr(ram_adr), .rd_adr(rd_adr), .rd_data(rd_data), .busy(busy),
    .row_done(row_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] vram(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) ram_data <= vram(ram_adr);

  always @(negedge clk) begin
    if (busreq) busreq_cyc <= busreq_cyc + 1;
    if (row_done) done_cnt <= done_cnt + 1;
    if (busy && !busreq) gap_cyc <= gap_cyc + 1;
    if (busreq_prev && !busreq && !row_done) falls <= falls + 1;
    busreq_prev <= busreq;
  end

  task automatic m_frame();
    m_start = m_start_sh; m_size = m_size_sh; m_src = m_start; m_cnt = '0;
  endtask

  task automatic m_push_row();
    for (int i = 0; i < ROW_BYTES; i++) begin
      exp_q.push_back(vram(m_src));
      if (m_cnt == m_size) begin m_src = m_start; m_cnt = '0; end
      else begin m_src = m_src + 16'd1; m_cnt = m_cnt + 15'd1; end
    end
  endtask

  task automatic wr(input bit sel, input logic [7:0] d, input bit clr);
    @(negedge clk); reg_we = 1'b1; reg_sel = sel; reg_wdata = d; ff_clr = clr;
    @(negedge clk); reg_we = 1'b0; ff_clr = 1'b0;
    if (!sel) begin
      if (m_ff0) m_start_sh[15:8] = d; else m_start_sh[7:0] = d;
      m_ff0 = !m_ff0;
    end else begin
      if (m_ff1) m_size_sh[14:8] = d[6:0]; else m_size_sh[7:0] = d;
      m_ff1 = !m_ff1;
    end
    if (clr) begin m_ff0 = 0; m_ff1 = 0; end
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    m_frame();
  endtask

  // Pulses row_req; returns the first address the row should fetch.
  task automatic start_row(input bit push, output logic [15:0] first);
    first = m_src;
    @(negedge clk); row_req = 1'b1;
    @(negedge clk); row_req = 1'b0;
    if (push) m_push_row();
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (row_done) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL row_done_timeout: no row_done within 3000 clk"); end
  endtask

  task automatic read_row(input string tag);
    logic [7:0] e;
    int bad = 0;
    @(negedge clk);
    for (int i = 0; i < ROW_BYTES; i++) begin
      rd_adr = 7'(i);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_chk++;
      if (rd_data !== e) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL %s_byte%0d: got %02h expected %02h", tag, i, rd_data, e);
      end
    end
  endtask

  task automatic test_reset();
    int d0;
    logic [15:0] f;
    reset = 1; frame_start = 0; row_req = 0; dma_en = 1; reg_we = 0; reg_sel = 0;
    reg_wdata = 0; ff_clr = 0; busack = 1; rd_adr = 0;
    m_start_sh = 16'hF300; m_size_sh = 15'd2999; m_ff0 = 0; m_ff1 = 0; m_frame();
    repeat (3) @(negedge clk);
    n_chk++; if ({busreq, busy, row_done, overrun} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busreq, busy, row_done, overrun}); end
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %02h expected 00", rd_data); end
    n_chk++; if (ram_adr !== 16'hF300) begin n_fail++; $display("FAIL reset_ram_adr: got %04h expected F300", ram_adr); end
    reset = 0;
    // Requests are ignored while DMA is disabled.
    dma_en = 0; d0 = done_cnt;
    start_row(0, f);
    repeat (10) @(negedge clk);
    n_chk++; if (busreq !== 1'b0 || done_cnt != d0) begin
      n_fail++; $display("FAIL dma_disabled: busreq %b done %0d expected 0 0", busreq, done_cnt - d0); end
    dma_en = 1;
  endtask

  task automatic test_basic();
    int b0, d0, g0;
    logic [15:0] f;
    pulse_fs();
    b0 = busreq_cyc; d0 = done_cnt; g0 = gap_cyc;
    start_row(1, f);
    n_chk++; if (ram_adr !== 16'hF300) begin n_fail++; $display("FAIL basic_first_adr: got %04h expected F300", ram_adr); end
    wait_done();
    read_row("basic");
    n_chk++; if (busreq_cyc - b0 != EXP_BUSREQ) begin
      n_fail++; $display("FAIL basic_busreq_cycles: got %0d expected %0d", busreq_cyc - b0, EXP_BUSREQ); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_row_done: got %0d expected 1", done_cnt - d0); end
    n_chk++; if (gap_cyc - g0 != EXP_GAPCYC) begin
      n_fail++; $display("FAIL basic_gap_cycles: got %0d expected %0d", gap_cyc - g0, EXP_GAPCYC); end
  endtask

  task automatic test_regs();
    logic [15:0] f;
    // ff_clr alongside a write: the low byte is written but the flip-flop stays at 0.
    wr(0, 8'h12, 1); wr(0, 8'h00, 0); wr(0, 8'hC0, 0);
    start_row(1, f);
    n_chk++; if (ram_adr !== f || f !== 16'hF378) begin
      n_fail++; $display("FAIL regs_old_adr: got %04h expected F378", ram_adr); end
    wait_done(); read_row("regs_old");
    pulse_fs();
    start_row(1, f);
    n_chk++; if (ram_adr !== 16'hC000) begin n_fail++; $display("FAIL regs_new_adr: got %04h expected C000", ram_adr); end
    wait_done(); read_row("regs_new");
  endtask

  task automatic test_wrap();
    logic [15:0] f;
    wr(1, 8'h77, 0); wr(1, 8'h00, 0);
    pulse_fs();
    start_row(1, f); wait_done(); read_row("wrap1");
    start_row(1, f);
    n_chk++; if (ram_adr !== 16'hC000) begin n_fail++; $display("FAIL wrap_restart_adr: got %04h expected C000", ram_adr); end
    wait_done(); read_row("wrap2");
  endtask

  task automatic test_stall();
    int fl0;
    logic [15:0] f;
    busack = 0; fl0 = falls;
    start_row(1, f);
    repeat (10) @(negedge clk);
    n_chk++; if (busreq !== 1'b1) begin n_fail++; $display("FAIL stall_grant_busreq: got %b expected 1", busreq); end
    busack = 1;
    repeat (40) @(negedge clk);
    busack = 0;
    repeat (5) @(negedge clk);
    busack = 1;
    wait_done();
    n_chk++; if (falls - fl0 != EXP_FALLS) begin
      n_fail++; $display("FAIL stall_busreq_drops: got %0d expected %0d", falls - fl0, EXP_FALLS); end
    read_row("stall");
  endtask

  task automatic test_overrun_abort();
    int d0;
    logic [15:0] f;
    d0 = done_cnt;
    start_row(1, f);
    repeat (20) @(negedge clk);
    row_req = 1; @(negedge clk); row_req = 0;
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    wait_done(); read_row("overrun");
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL overrun_rows: got %0d expected 1", done_cnt - d0); end
    d0 = done_cnt;
    start_row(0, f);
    repeat (20) @(negedge clk);
    pulse_fs();
    n_chk++; if ({busreq, busy, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL abort_flags: got %b expected 000", {busreq, busy, overrun}); end
    repeat (300) @(negedge clk);
    n_chk++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_row_done: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_simul();
    logic [15:0] f;
    wr(0, 8'hF0, 0); wr(0, 8'h10, 0);
    @(negedge clk); frame_start = 1; row_req = 1;
    @(negedge clk); frame_start = 0; row_req = 0;
    m_frame(); f = m_src; m_push_row();
    n_chk++; if (ram_adr !== 16'h10F0 || f !== 16'h10F0) begin
      n_fail++; $display("FAIL simul_first_adr: got %04h expected 10F0", ram_adr); end
    wait_done(); read_row("simul");
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_regs();
    test_wrap();
    test_stall();
    test_overrun_abort();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
